// File: rtl/signed_adder_tree_sat.sv
// -----------------------------------------------------------------------------
// signed_adder_tree_sat
//
// Parametrised N-input sign-magnitude adder tree. It produces a saturating,
// unsigned output slice and carries a sideband delay line that stays aligned
// with the data.
//
// Pipeline (LATENCY = LOG2N + 2 register stages):
//   stage 1           : each sign-magnitude operand becomes SUM_WIDTH two's
//                       complement
//   stages 2..LOG2N+1 : pairwise adder tree, one level per stage
//   output stage      : clip/saturate the final sum into an OUT_WIDTH slice
//
// Optional build macro:
//   SIGNED_ADDER_TREE_ROUND_EN - round half up at bit OUT_LSB before the
//                                saturation check (otherwise truncate)
//
// Ports:
//   clk        in   clock, every register updates on the rising edge
//   resetn     in   asynchronous active-low reset
//   valid_in   in   operands valid this cycle
//   data_in    in   packed operands, operand k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ddata_in   in   sideband input
//   valid_out  out  data_p / clip flags valid
//   data_p     out  saturated unsigned result slice
//   clip_lo    out  sum was negative, data_p forced to 0
//   clip_hi    out  sum exceeded the slice, data_p forced to all ones
//   ddata_out  out  ddata_in delayed by LATENCY cycles
// -----------------------------------------------------------------------------
module signed_adder_tree_sat #(
  parameter int NUM_INPUTS       = 4,
  parameter int DATA_WIDTH       = 25,
  parameter int OUT_WIDTH        = 8,
  parameter int OUT_LSB          = 12,
  parameter int DELAY_DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             valid_in,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [DELAY_DATA_WIDTH-1:0]      ddata_in,
  output logic                             valid_out,
  output logic [OUT_WIDTH-1:0]             data_p,
  output logic                             clip_lo,
  output logic                             clip_hi,
  output logic [DELAY_DATA_WIDTH-1:0]      ddata_out
);

  localparam int LOG2N     = $clog2(NUM_INPUTS);
  localparam int SUM_WIDTH = DATA_WIDTH + LOG2N;
  localparam int LATENCY   = LOG2N + 2;
  localparam int SLICE_TOP = OUT_LSB + OUT_WIDTH;

  // Elaboration-time parameter sanity checks.
  if (NUM_INPUTS < 2 || NUM_INPUTS > 16 || (1 << LOG2N) != NUM_INPUTS) begin : g_bad_num_inputs
    $error("NUM_INPUTS must be a power of 2 in 2..16");
  end
  if (SLICE_TOP > SUM_WIDTH - 1) begin : g_bad_slice
    $error("OUT_LSB + OUT_WIDTH must not exceed SUM_WIDTH - 1");
  end
`ifdef SIGNED_ADDER_TREE_ROUND_EN
  if (OUT_LSB < 1) begin : g_bad_round
    $error("rounding needs OUT_LSB >= 1");
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 1 input: sign-magnitude to two's complement.
  // The magnitude is zero-extended to SUM_WIDTH and negated when the sign bit
  // is set. Negative zero negates to zero, so it needs no special case.
  // ---------------------------------------------------------------------------
  logic [SUM_WIDTH-1:0] conv [NUM_INPUTS];

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_conv
    logic                 sign_bit;
    logic [SUM_WIDTH-1:0] mag_ext;

    assign sign_bit = data_in[k*DATA_WIDTH + DATA_WIDTH - 1];
    assign mag_ext  = SUM_WIDTH'(data_in[k*DATA_WIDTH +: DATA_WIDTH-1]);
    assign conv[k]  = sign_bit ? -mag_ext : mag_ext;
  end

  // ---------------------------------------------------------------------------
  // Adder tree stored as a heap.
  // Leaves node[N..2N-1] hold the converted operands (stage 1). Each internal
  // node i registers node[2i] + node[2i+1], so every heap depth is exactly one
  // pipeline stage. The root node[1] is the final sum S.
  // Growing the sum by LOG2N bits means no level can overflow.
  // ---------------------------------------------------------------------------
  logic [SUM_WIDTH-1:0] node [1:2*NUM_INPUTS-1];

  // NOTE: every pipeline register is non-blocking. All heap levels therefore
  // read the previous cycle's children and advance together, one stage per edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: this array is a set of pipeline flops, not a RAM, so resetting
      // it is cheap. The reset also guarantees that no stale partial sums leak
      // out after a mid-stream reset.
      for (int i = 1; i < 2*NUM_INPUTS; i++) begin
        node[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        node[NUM_INPUTS + k] <= conv[k];
      end
      for (int i = 1; i < NUM_INPUTS; i++) begin
        node[i] <= node[2*i] + node[2*i+1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: clip negative sums to 0. Saturate sums whose bits above the
  // slice are non-zero. Otherwise take the slice.
  // The sign bit is known to be 0 in the overflow branch, so a whole-word shift
  // tests exactly the bits between the slice and the sign. This still holds
  // when that range is empty.
  // ---------------------------------------------------------------------------
  logic [SUM_WIDTH-1:0] sum_s;
  logic [OUT_WIDTH-1:0] data_p_d;
  logic                 clip_lo_d;
  logic                 clip_hi_d;

  assign sum_s = node[1];

`ifdef SIGNED_ADDER_TREE_ROUND_EN
  localparam logic [SUM_WIDTH:0] ROUND_HALF = (SUM_WIDTH+1)'(1) << (OUT_LSB - 1);

  // One extra bit holds the rounding carry. That carry then shows up as
  // overflow in the saturation check.
  logic [SUM_WIDTH:0] sum_r;

  assign sum_r = {1'b0, sum_s} + ROUND_HALF;

  // NOTE: outputs get defaults before any branch, so no path can leave them
  // unassigned and no latch is inferred.
  always_comb begin
    data_p_d  = '0;
    clip_lo_d = 1'b0;
    clip_hi_d = 1'b0;
    if (sum_s[SUM_WIDTH-1]) begin
      clip_lo_d = 1'b1;
    end else if ((sum_r >> SLICE_TOP) != '0) begin
      data_p_d  = '1;
      clip_hi_d = 1'b1;
    end else begin
      data_p_d = sum_r[SLICE_TOP-1:OUT_LSB];
    end
  end
`else
  // NOTE: outputs get defaults before any branch, so no path can leave them
  // unassigned and no latch is inferred.
  always_comb begin
    data_p_d  = '0;
    clip_lo_d = 1'b0;
    clip_hi_d = 1'b0;
    if (sum_s[SUM_WIDTH-1]) begin
      clip_lo_d = 1'b1;
    end else if ((sum_s >> SLICE_TOP) != '0) begin
      data_p_d  = '1;
      clip_hi_d = 1'b1;
    end else begin
      data_p_d = sum_s[SLICE_TOP-1:OUT_LSB];
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_p  <= '0;
      clip_lo <= 1'b0;
      clip_hi <= 1'b0;
    end else begin
      data_p  <= data_p_d;
      clip_lo <= clip_lo_d;
      clip_hi <= clip_hi_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Valid and sideband delay lines, LATENCY stages deep, aligned with the data.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0]          valid_pipe;
  logic [DELAY_DATA_WIDTH-1:0] ddata_pipe [LATENCY];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        ddata_pipe[i] <= '0;
      end
    end else begin
      valid_pipe    <= {valid_pipe[LATENCY-2:0], valid_in};
      ddata_pipe[0] <= ddata_in;
      for (int i = 1; i < LATENCY; i++) begin
        ddata_pipe[i] <= ddata_pipe[i-1];
      end
    end
  end

  assign valid_out = valid_pipe[LATENCY-1];
  assign ddata_out = ddata_pipe[LATENCY-1];

endmodule

// File: doc/signed_adder_tree_sat.md
Name: signed_adder_tree_sat

Overview:
Parametrised N-input sign-magnitude adder tree with saturating unsigned output slice. Successor to the fixed 4-input, 25-bit summing block used in the colour-space/scaler datapaths. Adds:
- Generic input count and widths
- Sum-width growth, so the tree never overflows internally
- Valid tracking and clip flags
- Asynchronous active-low reset
Sits between per-channel multiplier stages and the 8-bit pixel output register, with a sideband delay line kept aligned to the data.

Parameters:
NUM_INPUTS, 4, number of operands; power of 2, 2..16
DATA_WIDTH, 25, operand width incl. sign bit (MSB = sign, rest = magnitude)
OUT_WIDTH, 8, output slice width
OUT_LSB, 12, sum bit mapped to data_p[0]; require OUT_LSB+OUT_WIDTH <= SUM_WIDTH-1
DELAY_DATA_WIDTH, 16, sideband delay-line width
(derived) LOG2N = log2(NUM_INPUTS); SUM_WIDTH = DATA_WIDTH+LOG2N; LATENCY = LOG2N+2

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
valid_in  in  1  operands valid this cycle
data_in  in  NUM_INPUTS*DATA_WIDTH  packed operands; operand k at [k*DATA_WIDTH +: DATA_WIDTH]
ddata_in  in  DELAY_DATA_WIDTH  sideband in
valid_out  out  1  data_p/flags valid
data_p  out  OUT_WIDTH  saturated unsigned result
clip_lo  out  1  result was negative, forced to 0
clip_hi  out  1  result exceeded slice, forced to all ones
ddata_out  out  DELAY_DATA_WIDTH  sideband delayed by LATENCY

Behaviour:
- Reset (resetn=0, asynchronous): all pipeline registers, valid_out, data_p, clip_lo, clip_hi and ddata_out go to 0 immediately and stay 0 until the first clk edge after deassertion.
- Pipeline is free-running: every register updates every cycle. valid and ddata shift alongside the data. Result for inputs sampled at edge T appears after edge T+LATENCY-1 (LATENCY edges of registering). Full throughput, no stalls.
- Stage 1, conversion:
  - Each operand is converted to SUM_WIDTH two's complement: magnitude is zero-extended; if sign=1 the value is negated.
  - Negative zero (sign=1, magnitude=0) yields 0.
- Stages 2..LOG2N+1, adder tree:
  - Pairwise SUM_WIDTH additions, one tree level per stage (4->2->1 for N=4).
  - No overflow is possible, since the operand magnitude is at most 2^(DATA_WIDTH-1)-1.
- Output stage, evaluated in priority order on final sum S:
  1. S[SUM_WIDTH-1]=1 -> data_p=0, clip_lo=1, clip_hi=0.
  2. Else if any bit S[SUM_WIDTH-2:OUT_LSB+OUT_WIDTH] is 1 -> data_p = all ones, clip_hi=1, clip_lo=0.
  3. Else data_p = S[OUT_LSB+OUT_WIDTH-1:OUT_LSB] (truncation), both flags 0.
- Flags and data_p are produced every cycle. They are meaningful only when valid_out=1.
- Reset mid-stream: in-flight samples are discarded. valid_out=0 until LATENCY cycles after the first valid_in accepted post-reset.
- NUM_INPUTS=2: one tree level, LATENCY=3.

Optional Feature:
Macro SIGNED_ADDER_TREE_ROUND_EN.
- Defined: in the output stage, a non-negative S has 2^(OUT_LSB-1) added (round half up) in SUM_WIDTH+1 bits before the saturation check. A carry out of the slice saturates to all ones with clip_hi=1. Requires OUT_LSB>=1. Latency unchanged.
- Undefined: plain truncation as above.

Test Plan:
- Defaults, 4 operands each 0x0001000, valid_in pulse -> 4 edges later valid_out=1, data_p=0x04, clip flags 0, ddata_out equals the ddata_in sampled with that pulse.
- Operands {0x1010000, 0, 0, 0} -> data_p=0x00, clip_lo=1.
- Operands {0x0100000, 0, 0, 0} -> data_p=0xFF, clip_hi=1.
- Operands all 0x0FFFFFF (sum 0x3FFFFFC, would overflow 25 bits) -> data_p=0xFF, clip_hi=1, no wrap to negative.
- Operands {0x1000000, 0x0003000, 0, 0} (negative zero) -> data_p=0x03.
- Streaming ramp of 16 back-to-back valids, then resetn pulse mid-stream -> outputs cleared asynchronously; no stale valid_out after release.
- Operands {0x0000800, 0, 0, 0} -> data_p=0x00 without macro, 0x01 with SIGNED_ADDER_TREE_ROUND_EN.
